// File: rtl/tlul_dev_responder.sv
// Device-side TL-UL responder: turns one A-channel request into a single register-bus access
// and returns the matching D-channel AccessAck/AccessAckData, or an error response without a bus access.
module tlul_dev_responder #(
    parameter logic [31:0] ADDR_SPACE = 32'h40080000,
    parameter logic [31:0] ADDR_MASK  = 32'h0000ffff,
    parameter int unsigned SRC_W      = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [2:0]       a_opcode_i,
    input  logic [1:0]       a_size_i,
    input  logic [SRC_W-1:0] a_source_i,
    input  logic [31:0]      a_address_i,
    input  logic [3:0]       a_mask_i,
    input  logic [31:0]      a_data_i,

    output logic             d_valid_o,
    input  logic             d_ready_i,
    output logic [2:0]       d_opcode_o,
    output logic [1:0]       d_size_o,
    output logic [SRC_W-1:0] d_source_o,
    output logic [31:0]      d_data_o,
    output logic             d_error_o,

    output logic             reg_req_o,
    output logic             reg_we_o,
    output logic [31:0]      reg_addr_o,
    output logic [31:0]      reg_wdata_o,
    output logic [3:0]       reg_be_o,
    input  logic             reg_rvalid_i,
    input  logic [31:0]      reg_rdata_i,
    input  logic             reg_err_i
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic TIMEOUT_EN = (TIMEOUT > 0);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e             state_q;
    logic               isGet_q;
    logic [CNT_W-1:0]   timer_q;

    logic               a_ready_q;
    logic               d_valid_q;
    logic [2:0]         d_opcode_q;
    logic [1:0]         d_size_q;
    logic [SRC_W-1:0]   d_source_q;
    logic [31:0]        d_data_q;
    logic               d_error_q;
    logic               reg_req_q;
    logic               reg_we_q;
    logic [31:0]        reg_addr_q;
    logic [31:0]        reg_wdata_q;
    logic [3:0]         reg_be_q;

    logic [3:0]         sizeLanes;
    logic               alignOk;
    logic               opcodeOk;
    logic               windowOk;
    logic               maskOk;
    logic               fullMaskOk;
    logic               reqError;
    logic               reqIsGet;
    logic [31:0]        maskedAddr;

    // Byte lanes the request may touch, derived from size and the low address bits.
    always_comb begin
        sizeLanes = 4'b0000;
        alignOk   = 1'b0;
        case (a_size_i)
            2'd0: begin
                sizeLanes = 4'b0001 << a_address_i[1:0];
                alignOk   = 1'b1;
            end
            2'd1: begin
                sizeLanes = a_address_i[1] ? 4'b1100 : 4'b0011;
                alignOk   = ~a_address_i[0];
            end
            2'd2: begin
                sizeLanes = 4'b1111;
                alignOk   = (a_address_i[1:0] == 2'b00);
            end
            default: begin
                sizeLanes = 4'b0000;
                alignOk   = 1'b0;
            end
        endcase
    end

    assign reqIsGet   = (a_opcode_i == OP_GET);
    assign opcodeOk   = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PARTIAL) || reqIsGet;
    assign windowOk   = ((a_address_i & ~ADDR_MASK) == ADDR_SPACE);
    assign maskOk     = ((a_mask_i & ~sizeLanes) == 4'b0000);
    assign fullMaskOk = (a_opcode_i != OP_PUT_FULL) || (a_mask_i == sizeLanes);
    assign reqError   = ~(opcodeOk && windowOk && alignOk && maskOk && fullMaskOk);
    assign maskedAddr = a_address_i & ADDR_MASK;

    // Single-transaction FSM; every interface output comes straight from a register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            isGet_q     <= 1'b0;
            timer_q     <= '0;
            a_ready_q   <= 1'b1;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= 3'd0;
            d_size_q    <= 2'd0;
            d_source_q  <= '0;
            d_data_q    <= 32'd0;
            d_error_q   <= 1'b0;
            reg_req_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= 32'd0;
            reg_wdata_q <= 32'd0;
            reg_be_q    <= 4'd0;
        end else begin
            reg_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_valid_i) begin
                        a_ready_q  <= 1'b0;
                        isGet_q    <= reqIsGet;
                        d_opcode_q <= reqIsGet ? 3'd1 : 3'd0;
                        d_size_q   <= a_size_i;
                        d_source_q <= a_source_i;
                        timer_q    <= '0;
                        if (reqError) begin
                            state_q   <= RESP;
                            d_valid_q <= 1'b1;
                            d_error_q <= 1'b1;
                            d_data_q  <= reqIsGet ? 32'hFFFF_FFFF : 32'd0;
                        end else begin
                            state_q     <= ACCESS;
                            reg_req_q   <= 1'b1;
                            reg_we_q    <= ~reqIsGet;
                            reg_addr_q  <= {maskedAddr[31:2], 2'b00};
                            reg_wdata_q <= a_data_i;
                            reg_be_q    <= a_mask_i;
                            d_error_q   <= 1'b0;
                            d_data_q    <= 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (reg_rvalid_i) begin
                        state_q   <= RESP;
                        d_valid_q <= 1'b1;
                        d_error_q <= reg_err_i;
                        if (isGet_q) begin
                            d_data_q <= reg_err_i ? 32'hFFFF_FFFF : reg_rdata_i;
                        end
                    end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                        state_q   <= RESP;
                        d_valid_q <= 1'b1;
                        d_error_q <= 1'b1;
                        if (isGet_q) begin
                            d_data_q <= 32'hFFFF_FFFF;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: begin
                    if (d_ready_i) begin
                        state_q   <= IDLE;
                        d_valid_q <= 1'b0;
                        a_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    d_valid_q <= 1'b0;
                    a_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign a_ready_o   = a_ready_q;
    assign d_valid_o   = d_valid_q;
    assign d_opcode_o  = d_opcode_q;
    assign d_size_o    = d_size_q;
    assign d_source_o  = d_source_q;
    assign d_data_o    = d_data_q;
    assign d_error_o   = d_error_q;
    assign reg_req_o   = reg_req_q;
    assign reg_we_o    = reg_we_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_be_o    = reg_be_q;

endmodule

// File: tb/tb_tlul_dev_responder.sv
// Directed bench for tlul_dev_responder: hand-computed responses for good, error,
// back-pressure, timeout and mid-transaction reset cases.
module tb_tlul_dev_responder;

    logic        clock;
    logic        reset;
    logic        aValid;
    logic        aReady;
    logic [2:0]  aOpcode;
    logic [1:0]  aSize;
    logic [7:0]  aSource;
    logic [31:0] aAddress;
    logic [3:0]  aMask;
    logic [31:0] aData;
    logic        dValid;
    logic        dReady;
    logic [2:0]  dOpcode;
    logic [1:0]  dSize;
    logic [7:0]  dSource;
    logic [31:0] dData;
    logic        dError;
    logic        regReq;
    logic        regWe;
    logic [31:0] regAddr;
    logic [31:0] regWdata;
    logic [3:0]  regBe;
    logic        regRvalid;
    logic [31:0] regRdata;
    logic        regErr;

    int vectorCount = 0;
    int missCount   = 0;
    int latency;

    tlul_dev_responder dut (
        .clk_i        (clock),
        .rst_i        (reset),
        .a_valid_i    (aValid),
        .a_ready_o    (aReady),
        .a_opcode_i   (aOpcode),
        .a_size_i     (aSize),
        .a_source_i   (aSource),
        .a_address_i  (aAddress),
        .a_mask_i     (aMask),
        .a_data_i     (aData),
        .d_valid_o    (dValid),
        .d_ready_i    (dReady),
        .d_opcode_o   (dOpcode),
        .d_size_o     (dSize),
        .d_source_o   (dSource),
        .d_data_o     (dData),
        .d_error_o    (dError),
        .reg_req_o    (regReq),
        .reg_we_o     (regWe),
        .reg_addr_o   (regAddr),
        .reg_wdata_o  (regWdata),
        .reg_be_o     (regBe),
        .reg_rvalid_i (regRvalid),
        .reg_rdata_i  (regRdata),
        .reg_err_i    (regErr)
    );

    // 10 ns clock; inputs change and outputs are sampled 1 ns after the rising edge.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case some wait loop misbehaves.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Presents one A-channel beat for one cycle; returns one cycle after acceptance.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                                 input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        int waitCycles = 0;
        while (!aReady && waitCycles < 20) begin
            stepCycle();
            waitCycles++;
        end
        checkOutput("a_ready_before_request", {31'd0, aReady}, 32'd1);
        aOpcode  = op;
        aSize    = size;
        aSource  = src;
        aAddress = addr;
        aMask    = mask;
        aData    = data;
        aValid   = 1'b1;
        stepCycle();
        aValid   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        aValid    = 1'b0;
        aOpcode   = 3'd0;
        aSize     = 2'd0;
        aSource   = 8'd0;
        aAddress  = 32'd0;
        aMask     = 4'd0;
        aData     = 32'd0;
        dReady    = 1'b1;
        regRvalid = 1'b0;
        regRdata  = 32'd0;
        regErr    = 1'b0;

        stepCycle();
        stepCycle();
        checkOutput("rst_a_ready", {31'd0, aReady}, 32'd1);
        checkOutput("rst_d_valid", {31'd0, dValid}, 32'd0);
        checkOutput("rst_reg_req", {31'd0, regReq}, 32'd0);
        checkOutput("rst_reg_we", {31'd0, regWe}, 32'd0);
        checkOutput("rst_d_error", {31'd0, dError}, 32'd0);
        checkOutput("rst_d_data", dData, 32'd0);
        checkOutput("rst_reg_addr", regAddr, 32'd0);
        checkOutput("rst_d_source", {24'd0, dSource}, 32'd0);
        reset = 1'b0;
        stepCycle();

        // Get with read data returned three cycles after the strobe
        applyStimulus(3'd4, 2'd2, 8'd5, 32'h4008_0010, 4'hF, 32'd0);
        checkOutput("get_reg_req", {31'd0, regReq}, 32'd1);
        checkOutput("get_reg_we", {31'd0, regWe}, 32'd0);
        checkOutput("get_reg_addr", regAddr, 32'h0000_0010);
        checkOutput("get_a_ready_low", {31'd0, aReady}, 32'd0);
        stepCycle();
        checkOutput("get_req_pulse", {31'd0, regReq}, 32'd0);
        stepCycle();
        checkOutput("get_no_early_dvalid", {31'd0, dValid}, 32'd0);
        stepCycle();
        regRvalid = 1'b1;
        regRdata  = 32'hDEAD_BEEF;
        stepCycle();
        regRvalid = 1'b0;
        checkOutput("get_d_valid", {31'd0, dValid}, 32'd1);
        checkOutput("get_d_opcode", {29'd0, dOpcode}, 32'd1);
        checkOutput("get_d_data", dData, 32'hDEAD_BEEF);
        checkOutput("get_d_source", {24'd0, dSource}, 32'd5);
        checkOutput("get_d_size", {30'd0, dSize}, 32'd2);
        checkOutput("get_d_error", {31'd0, dError}, 32'd0);
        stepCycle();
        checkOutput("get_d_valid_drop", {31'd0, dValid}, 32'd0);
        checkOutput("get_a_ready_back", {31'd0, aReady}, 32'd1);

        // PutFullData with rvalid coinciding with the strobe: d_valid two cycles after accept
        applyStimulus(3'd0, 2'd2, 8'd9, 32'h4008_0004, 4'hF, 32'h1234_5678);
        checkOutput("put_reg_req", {31'd0, regReq}, 32'd1);
        checkOutput("put_reg_we", {31'd0, regWe}, 32'd1);
        checkOutput("put_reg_addr", regAddr, 32'h0000_0004);
        checkOutput("put_reg_be", {28'd0, regBe}, 32'hF);
        checkOutput("put_reg_wdata", regWdata, 32'h1234_5678);
        checkOutput("put_no_dvalid_n1", {31'd0, dValid}, 32'd0);
        regRvalid = 1'b1;
        regRdata  = 32'hAAAA_AAAA;
        stepCycle();
        regRvalid = 1'b0;
        checkOutput("put_d_valid_n2", {31'd0, dValid}, 32'd1);
        checkOutput("put_d_opcode", {29'd0, dOpcode}, 32'd0);
        checkOutput("put_d_error", {31'd0, dError}, 32'd0);
        checkOutput("put_d_data", dData, 32'd0);
        stepCycle();

        // Out-of-window Get: error response one cycle after accept, no bus access
        applyStimulus(3'd4, 2'd2, 8'd3, 32'h4009_0000, 4'hF, 32'd0);
        checkOutput("oow_reg_req", {31'd0, regReq}, 32'd0);
        checkOutput("oow_d_valid_n1", {31'd0, dValid}, 32'd1);
        checkOutput("oow_d_error", {31'd0, dError}, 32'd1);
        checkOutput("oow_d_data", dData, 32'hFFFF_FFFF);
        checkOutput("oow_d_opcode", {29'd0, dOpcode}, 32'd1);
        stepCycle();

        // Misaligned PutPartialData size 1
        applyStimulus(3'd1, 2'd1, 8'd4, 32'h4008_0001, 4'h3, 32'h0);
        checkOutput("misalign_reg_req", {31'd0, regReq}, 32'd0);
        checkOutput("misalign_d_error", {31'd0, dError}, 32'd1);
        checkOutput("misalign_d_opcode", {29'd0, dOpcode}, 32'd0);
        checkOutput("misalign_d_data", dData, 32'd0);
        stepCycle();

        // PutFullData word with a half mask
        applyStimulus(3'd0, 2'd2, 8'd6, 32'h4008_0008, 4'h3, 32'h5);
        checkOutput("fullmask_d_valid", {31'd0, dValid}, 32'd1);
        checkOutput("fullmask_d_error", {31'd0, dError}, 32'd1);
        stepCycle();

        // Unsupported opcode 2
        applyStimulus(3'd2, 2'd2, 8'd7, 32'h4008_0008, 4'hF, 32'h5);
        checkOutput("badop_reg_req", {31'd0, regReq}, 32'd0);
        checkOutput("badop_d_error", {31'd0, dError}, 32'd1);
        checkOutput("badop_d_opcode", {29'd0, dOpcode}, 32'd0);
        stepCycle();

        // Byte Get whose mask lane does not match the address offset
        applyStimulus(3'd4, 2'd0, 8'd8, 32'h4008_0002, 4'h1, 32'h0);
        checkOutput("lane_d_error", {31'd0, dError}, 32'd1);
        checkOutput("lane_d_data", dData, 32'hFFFF_FFFF);
        stepCycle();

        // Legal byte PutPartialData; device reports an error
        applyStimulus(3'd1, 2'd0, 8'd10, 32'h4008_0006, 4'h4, 32'h00AB_0000);
        checkOutput("byte_reg_req", {31'd0, regReq}, 32'd1);
        checkOutput("byte_reg_addr", regAddr, 32'h0000_0004);
        checkOutput("byte_reg_be", {28'd0, regBe}, 32'h4);
        regRvalid = 1'b1;
        regErr    = 1'b1;
        stepCycle();
        regRvalid = 1'b0;
        regErr    = 1'b0;
        checkOutput("byte_d_error", {31'd0, dError}, 32'd1);
        checkOutput("byte_d_data", dData, 32'd0);
        stepCycle();

        // Back-pressure: D held for five cycles while a second request waits
        dReady = 1'b0;
        applyStimulus(3'd4, 2'd2, 8'h7A, 32'h4008_0020, 4'hF, 32'd0);
        regRvalid = 1'b1;
        regRdata  = 32'h0BAD_F00D;
        stepCycle();
        regRvalid = 1'b0;
        regRdata  = 32'h0;
        aOpcode   = 3'd0;
        aSize     = 2'd2;
        aSource   = 8'h11;
        aAddress  = 32'h4008_0000;
        aMask     = 4'hF;
        aData     = 32'h0000_0001;
        aValid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_d_valid", {31'd0, dValid}, 32'd1);
            checkOutput("bp_d_data", dData, 32'h0BAD_F00D);
            checkOutput("bp_d_source", {24'd0, dSource}, 32'h7A);
            checkOutput("bp_a_ready", {31'd0, aReady}, 32'd0);
            checkOutput("bp_no_reg_req", {31'd0, regReq}, 32'd0);
            stepCycle();
        end
        dReady = 1'b1;
        stepCycle();
        checkOutput("bp_release_d_valid", {31'd0, dValid}, 32'd0);
        checkOutput("bp_release_a_ready", {31'd0, aReady}, 32'd1);
        checkOutput("bp_release_no_req", {31'd0, regReq}, 32'd0);
        stepCycle();
        aValid = 1'b0;
        checkOutput("bp_second_req", {31'd0, regReq}, 32'd1);
        checkOutput("bp_second_we", {31'd0, regWe}, 32'd1);
        checkOutput("bp_second_wdata", regWdata, 32'h0000_0001);
        checkOutput("bp_second_addr", regAddr, 32'h0);
        regRvalid = 1'b1;
        stepCycle();
        regRvalid = 1'b0;
        checkOutput("bp_second_d_source", {24'd0, dSource}, 32'h11);
        stepCycle();

        // Timeout: no rvalid at all; error response after 255 waiting cycles
        applyStimulus(3'd4, 2'd2, 8'h22, 32'h4008_0030, 4'hF, 32'd0);
        latency = 1;
        while (!dValid && latency < 400) begin
            stepCycle();
            latency++;
        end
        checkOutput("timeout_latency", latency, 32'd256);
        checkOutput("timeout_d_error", {31'd0, dError}, 32'd1);
        checkOutput("timeout_d_data", dData, 32'hFFFF_FFFF);
        stepCycle();

        // Reset while in ACCESS: abort, no response, stray rvalid ignored afterwards
        applyStimulus(3'd4, 2'd2, 8'h33, 32'h4008_0040, 4'hF, 32'd0);
        checkOutput("abort_reg_req", {31'd0, regReq}, 32'd1);
        stepCycle();
        stepCycle();
        reset = 1'b1;
        #1;
        checkOutput("abort_a_ready", {31'd0, aReady}, 32'd1);
        checkOutput("abort_d_valid", {31'd0, dValid}, 32'd0);
        stepCycle();
        reset = 1'b0;
        regRvalid = 1'b1;
        regRdata  = 32'h5555_5555;
        stepCycle();
        regRvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("abort_no_d_valid", {31'd0, dValid}, 32'd0);
            checkOutput("abort_idle_ready", {31'd0, aReady}, 32'd1);
            stepCycle();
        end

        // Clean Get after the abort
        applyStimulus(3'd4, 2'd2, 8'h44, 32'h4008_00FC, 4'hF, 32'd0);
        checkOutput("recover_reg_addr", regAddr, 32'h0000_00FC);
        regRvalid = 1'b1;
        regRdata  = 32'hCAFE_0123;
        stepCycle();
        regRvalid = 1'b0;
        checkOutput("recover_d_valid", {31'd0, dValid}, 32'd1);
        checkOutput("recover_d_data", dData, 32'hCAFE_0123);
        checkOutput("recover_d_source", {24'd0, dSource}, 32'h44);
        stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
